// File: rtl/mem_scan_ctrl.sv
// Address scan controller: walks addr from a low to a high bound (modulo 256),
// either dwell-timed (auto) or one step per pulse (manual), with abort and done.
module mem_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       step,
  input  logic       abort,
  input  logic [7:0] lo_addr,
  input  logic [7:0] hi_addr,
  output logic [7:0] addr,
  output logic       rd_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      state_reg, state_next;
  logic [7:0]  hi_reg, hi_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  addr_next;
  logic        rd_en_next, busy_next, done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      hi_reg    <= 8'h00;
      cnt_reg   <= 16'd0;
      addr      <= 8'h00;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      cnt_reg   <= cnt_next;
      addr      <= addr_next;
      rd_en     <= rd_en_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight off a flop.
  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr;
    rd_en_next = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          addr_next  = lo_addr;
          hi_next    = hi_addr;
          cnt_next   = 16'd0;
          rd_en_next = 1'b1;
          busy_next  = 1'b1;
          state_next = mode ? MANUAL : AUTO;
        end
      end

      AUTO: begin
        busy_next = 1'b1;
        if (abort) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg == DWELL_LAST) begin
          cnt_next = 16'd0;
          if (addr == hi_reg) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = FINISH;
          end else begin
            addr_next  = addr + 8'd1;
            rd_en_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      MANUAL: begin
        busy_next = 1'b1;
        if (abort) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (step) begin
          if (addr == hi_reg) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = FINISH;
          end else begin
            addr_next  = addr + 8'd1;
            rd_en_next = 1'b1;
          end
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed bench for mem_scan_ctrl: one DWELL=4 and one DWELL=1 instance share stimulus.
module tb_mem_scan_ctrl;

  logic       clk, rst, start, mode, step, abort;
  logic [7:0] lo_addr, hi_addr;
  logic [7:0] a4, a1;
  logic       r4, b4, d4, r1, b1, d1;

  int checks = 0;
  int errors = 0;

  mem_scan_ctrl #(.DWELL(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step), .abort(abort),
    .lo_addr(lo_addr), .hi_addr(hi_addr),
    .addr(a4), .rd_en(r4), .busy(b4), .done(d4)
  );

  mem_scan_ctrl #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step), .abort(abort),
    .lo_addr(lo_addr), .hi_addr(hi_addr),
    .addr(a1), .rd_en(r1), .busy(b1), .done(d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; step = 1'b0; abort = 1'b0; mode = 1'b0;
    lo_addr = 8'h00; hi_addr = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns just after the accepting edge (edge 0).
  task automatic start_scan(input logic m, input logic [7:0] lo, input logic [7:0] hi);
    mode = m; lo_addr = lo; hi_addr = hi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; step = 1'b0; abort = 1'b0; mode = 1'b0;
    lo_addr = 8'h00; hi_addr = 8'h00;
    #2;
    checks++;
    if (a4 !== 8'h00 || r4 !== 1'b0 || b4 !== 1'b0 || d4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h rd=%b busy=%b done=%b exp 00 0 0 0", a4, r4, b4, d4);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (a4 !== 8'h00 || b4 !== 1'b0 || d4 !== 1'b0 || a1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle got addr=%h busy=%b done=%b addr1=%h exp 00 0 0 00", a4, b4, d4, a1);
    end
    $display("test_reset done");
  endtask

  // lo=0x10 hi=0x13 DWELL=4; a foreign start and a step arrive mid-scan.
  task automatic test_auto();
    logic [7:0] ea;
    logic er, eb, ed;
    do_reset();
    start_scan(1'b0, 8'h10, 8'h13);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        ea = 8'h10 + 8'((c - 1) / 4); er = ((c - 1) % 4 == 0); eb = 1'b1; ed = 1'b0;
      end else begin
        ea = 8'h13; er = 1'b0; eb = 1'b0; ed = (c == 17);
      end
      checks++;
      if (a4 !== ea) begin errors++; $display("FAIL auto_addr c=%0d got %h exp %h", c, a4, ea); end
      checks++;
      if (r4 !== er) begin errors++; $display("FAIL auto_rd_en c=%0d got %b exp %b", c, r4, er); end
      checks++;
      if (b4 !== eb) begin errors++; $display("FAIL auto_busy c=%0d got %b exp %b", c, b4, eb); end
      checks++;
      if (d4 !== ed) begin errors++; $display("FAIL auto_done c=%0d got %b exp %b", c, d4, ed); end
      if (c == 6) begin
        start = 1'b1; mode = 1'b1; lo_addr = 8'h55; hi_addr = 8'h60;
      end else if (c == 7) begin
        start = 1'b0; step = 1'b1;
      end else begin
        step = 1'b0;
      end
    end
    $display("test_auto done");
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    logic [7:0] ea;
    logic er, eb, ed;
    seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h01;
    do_reset();
    start_scan(1'b0, 8'hFE, 8'h01);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        ea = seq[c - 1]; er = 1'b1; eb = 1'b1; ed = 1'b0;
      end else begin
        ea = 8'h01; er = 1'b0; eb = 1'b0; ed = (c == 5);
      end
      checks++;
      if (a1 !== ea || r1 !== er || b1 !== eb || d1 !== ed) begin
        errors++;
        $display("FAIL wrap c=%0d got addr=%h rd=%b busy=%b done=%b exp %h %b %b %b",
                 c, a1, r1, b1, d1, ea, er, eb, ed);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_manual_single();
    logic er, eb, ed;
    do_reset();
    start_scan(1'b1, 8'h20, 8'h20);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      er = (c == 1); eb = (c <= 3); ed = (c == 4);
      checks++;
      if (a4 !== 8'h20 || r4 !== er || b4 !== eb || d4 !== ed) begin
        errors++;
        $display("FAIL manual_single c=%0d got addr=%h rd=%b busy=%b done=%b exp 20 %b %b %b",
                 c, a4, r4, b4, d4, er, eb, ed);
      end
      step = (c == 3);
    end
    step = 1'b0;
    $display("test_manual_single done");
  endtask

  task automatic test_manual_multi();
    logic [7:0] ea;
    logic er, eb, ed;
    do_reset();
    start_scan(1'b1, 8'h30, 8'h32);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ea = (c < 3) ? 8'h30 : (c < 5) ? 8'h31 : 8'h32;
      er = (c == 1 || c == 3 || c == 5); eb = (c <= 6); ed = (c == 7);
      checks++;
      if (a4 !== ea || r4 !== er || b4 !== eb || d4 !== ed) begin
        errors++;
        $display("FAIL manual_multi c=%0d got addr=%h rd=%b busy=%b done=%b exp %h %b %b %b",
                 c, a4, r4, b4, d4, ea, er, eb, ed);
      end
      step = (c == 2 || c == 4 || c == 6);
    end
    step = 1'b0;
    $display("test_manual_multi done");
  endtask

  task automatic test_abort();
    logic [7:0] ea, ea1;
    logic er, eb;
    do_reset();
    start_scan(1'b0, 8'h00, 8'hFF);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c <= 10) begin
        ea = 8'((c - 1) / 4); er = ((c - 1) % 4 == 0); eb = 1'b1; ea1 = 8'(c - 1);
      end else begin
        ea = 8'h02; er = 1'b0; eb = 1'b0; ea1 = 8'h09;
      end
      checks++;
      if (a4 !== ea || r4 !== er || b4 !== eb || d4 !== 1'b0) begin
        errors++;
        $display("FAIL abort_auto c=%0d got addr=%h rd=%b busy=%b done=%b exp %h %b %b 0",
                 c, a4, r4, b4, d4, ea, er, eb);
      end
      checks++;
      if (a1 !== ea1 || (c >= 11 && (r1 !== 1'b0 || b1 !== 1'b0 || d1 !== 1'b0))) begin
        errors++;
        $display("FAIL abort_dwell1 c=%0d got addr=%h rd=%b busy=%b done=%b exp addr %h",
                 c, a1, r1, b1, d1, ea1);
      end
      abort = (c == 10);
    end
    abort = 1'b0;
    // abort beats step in manual mode
    start_scan(1'b1, 8'h40, 8'h40);
    @(negedge clk);
    step = 1'b1; abort = 1'b1;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      step = 1'b0; abort = 1'b0;
      checks++;
      if (a4 !== 8'h40 || r4 !== 1'b0 || b4 !== 1'b0 || d4 !== 1'b0) begin
        errors++;
        $display("FAIL abort_manual c=%0d got addr=%h rd=%b busy=%b done=%b exp 40 0 0 0",
                 c, a4, r4, b4, d4);
      end
    end
    // start with abort in idle is refused
    abort = 1'b1;
    start_scan(1'b0, 8'h77, 8'h78);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (a4 !== 8'h40 || r4 !== 1'b0 || b4 !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle got addr=%h rd=%b busy=%b exp 40 0 0", a4, r4, b4);
    end
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    logic [7:0] ea;
    do_reset();
    start_scan(1'b0, 8'h00, 8'hFF);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      ea = 8'((c - 1) / 4);
      checks++;
      if (a4 !== ea || b4 !== 1'b1) begin
        errors++;
        $display("FAIL async_pre c=%0d got addr=%h busy=%b exp %h 1", c, a4, b4, ea);
      end
      step = (c == 3);
    end
    #1 rst = 1'b1; step = 1'b1;
    #1;
    checks++;
    if (a4 !== 8'h00 || b4 !== 1'b0 || r4 !== 1'b0 || d4 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got addr=%h busy=%b rd=%b done=%b exp 00 0 0 0", a4, b4, r4, d4);
    end
    #1 rst = 1'b0; step = 1'b0;
    for (int c = 23; c <= 25; c++) begin
      @(negedge clk);
      checks++;
      if (a4 !== 8'h00 || b4 !== 1'b0 || d4 !== 1'b0) begin
        errors++;
        $display("FAIL async_after c=%0d got addr=%h busy=%b done=%b exp 00 0 0", c, a4, b4, d4);
      end
    end
    start_scan(1'b0, 8'hA0, 8'hA0);
    @(negedge clk);
    checks++;
    if (a4 !== 8'hA0 || r4 !== 1'b1 || b4 !== 1'b1) begin
      errors++;
      $display("FAIL async_restart got addr=%h rd=%b busy=%b exp a0 1 1", a4, r4, b4);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_auto();
    test_wrap();
    test_manual_single();
    test_manual_multi();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
